// File: rtl/regfile_scan_pkg.sv
// Shared types and constants for the register-file read scanner.
// Holds the scan FSM state encoding and the default data/address widths.
package regfile_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int REG_COUNT        = 32;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 5;

endpackage

// File: rtl/regfile_scan.sv
// Walks a contiguous, optionally wrapping range of register-file addresses
// through one read port and emits each captured word on a valid/ready stream.
module regfile_scan
    import regfile_scan_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] first_reg,
    input  logic [ADDR_WIDTH-1:0] last_reg,
    output logic [ADDR_WIDTH-1:0] ctrl_readReg,
    input  logic [DATA_WIDTH-1:0] data_readReg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cur;
    logic [ADDR_WIDTH-1:0] r_end;
    logic                  w_handshake;
    logic [ADDR_WIDTH-1:0] w_cur_next;

    // The read port address comes straight from the scan pointer, so it is
    // valid for the whole READ cycle and simply parks in IDLE/DONE.
    assign ctrl_readReg = r_cur;
    assign w_handshake  = out_valid && out_ready;
    assign w_cur_next   = r_cur + ADDR_WIDTH'(1);

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_state   <= ST_IDLE;
            r_cur     <= '0;
            r_end     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cur   <= first_reg;
                        r_end   <= last_reg;
                        busy    <= 1'b1;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        out_data  <= data_readReg;
                        out_addr  <= r_cur;
                        out_last  <= (r_cur == r_end);
                        out_valid <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // An abort that lands on a handshake still lets the word
                    // go; it only suppresses the rest of the scan and done.
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_handshake) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_cur   <= w_cur_next;
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_scan.sv
// Directed bench for regfile_scan: a behavioural register file feeds the read
// port and every streamed word is compared against hand-derived expectations.
module tb_regfile_scan;
    import regfile_scan_pkg::*;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        start;
    logic        abort;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  ctrl_readReg;
    logic [31:0] data_readReg;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regs [REG_COUNT];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clock = ~clock;

    assign data_readReg = regs[ctrl_readReg];

    regfile_scan #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .start        (start),
        .abort        (abort),
        .first_reg    (first_reg),
        .last_reg     (last_reg),
        .ctrl_readReg (ctrl_readReg),
        .data_readReg (data_readReg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_addr     (out_addr),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: out_ready held high, mode 1: random stalls.
    // abort_at >= 0 aborts on the handshake of that word index.
    task automatic run_scan(input logic [4:0] f, input logic [4:0] l, input int mode,
                            input int abort_at, input bit spam,
                            output int words, output int done_cyc, output int busy_cyc);
        logic [4:0]  span;
        logic [4:0]  exp_addr;
        int          n_exp;
        int          idx;
        bit          stall_pend;
        bit          aborted;
        int          bad;
        logic [31:0] s_data;
        logic [4:0]  s_addr;
        logic        s_last;
        span       = l - f;
        n_exp      = int'(span) + 1;
        idx        = 0;
        stall_pend = 1'b0;
        aborted    = 1'b0;
        done_cyc   = -1;
        busy_cyc   = 0;
        s_data     = '0;
        s_addr     = '0;
        s_last     = 1'b0;
        @(negedge clock);
        start     = 1'b1;
        first_reg = f;
        last_reg  = l;
        out_ready = (mode == 0);
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(negedge clock);
            if (spam && !done) begin
                start     = 1'b1;
                first_reg = 5'd0;
                last_reg  = 5'd31;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (stall_pend) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data",  out_data, s_data);
                check("stall_addr",  32'(out_addr), 32'(s_addr));
                check("stall_last",  32'(out_last), 32'(s_last));
            end else if (out_valid) begin
                exp_addr = f + 5'(idx);
                check("word_addr", 32'(out_addr), 32'(exp_addr));
                check("word_data", out_data, regs[exp_addr]);
                check("word_last", 32'(out_last), 32'(idx == n_exp - 1));
                if (exp_addr == 5'd0) check("reg0_zero", out_data, 32'd0);
            end
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (out_valid && idx == abort_at) begin
                out_ready = 1'b1;
                abort     = 1'b1;
                aborted   = 1'b1;
            end
            stall_pend = out_valid && !out_ready;
            s_data = out_data;
            s_addr = out_addr;
            s_last = out_last;
            if (out_valid && out_ready) idx++;
            if (aborted) break;
        end
        start = 1'b0;
        if (aborted) begin
            @(negedge clock);
            abort = 1'b0;
            check("abort_busy",  32'(busy), 32'd0);
            check("abort_valid", 32'(out_valid), 32'd0);
            bad = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clock);
                if (out_valid || done || busy) bad++;
            end
            check("abort_quiet", 32'(bad), 32'd0);
        end else begin
            @(negedge clock);
            check("done_pulse_end", 32'(done), 32'd0);
            check("busy_end",       32'(busy), 32'd0);
        end
        words     = idx;
        out_ready = 1'b0;
    endtask

    initial begin
        int words, dcyc, bcyc;
        for (int i = 0; i < REG_COUNT; i++) regs[i] = 32'(i) * 32'h11;
        ctrl_reset_n = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        first_reg = '0;
        last_reg  = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  out_data, 32'd0);
        check("rst_addr",  32'(out_addr), 32'd0);
        check("rst_last",  32'(out_last), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_rdreg", 32'(ctrl_readReg), 32'd0);
        ctrl_reset_n = 1'b1;
        @(negedge clock);

        // Full scan 1..31 at full rate.
        run_scan(5'd1, 5'd31, 0, -1, 1'b0, words, dcyc, bcyc);
        check("t1_words", 32'(words), 32'd31);
        check("t1_done",  32'(dcyc), 32'd63);
        check("t1_busy",  32'(bcyc), 32'd63);

        // Wrapping scan 30..2 with random back-pressure.
        run_scan(5'd30, 5'd2, 1, -1, 1'b0, words, dcyc, bcyc);
        check("t2_words", 32'(words), 32'd5);
        check("t2_done_seen", 32'(dcyc > 0), 32'd1);

        // Single-word scan.
        regs[8] = 32'hDEADBEEF;
        run_scan(5'd8, 5'd8, 0, -1, 1'b0, words, dcyc, bcyc);
        check("t3_words", 32'(words), 32'd1);
        check("t3_done",  32'(dcyc), 32'd3);
        check("t3_busy",  32'(bcyc), 32'd3);
        regs[8] = 32'h88;

        // Abort on the third word's handshake.
        run_scan(5'd4, 5'd20, 0, 2, 1'b0, words, dcyc, bcyc);
        check("t4_words", 32'(words), 32'd3);
        check("t4_no_done", 32'(dcyc), 32'hFFFFFFFF);

        // Asynchronous reset in the middle of a scan.
        @(negedge clock);
        start = 1'b1; first_reg = 5'd0; last_reg = 5'd31; out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        #2 ctrl_reset_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_busy",  32'(busy), 32'd0);
        check("t5_rst_done",  32'(done), 32'd0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        run_scan(5'd5, 5'd9, 0, -1, 1'b0, words, dcyc, bcyc);
        check("t5_words", 32'(words), 32'd5);
        check("t5_done",  32'(dcyc), 32'd11);

        // start hammered while busy must not disturb the range.
        run_scan(5'd12, 5'd15, 0, -1, 1'b1, words, dcyc, bcyc);
        check("t6_words", 32'(words), 32'd4);
        check("t6_done",  32'(dcyc), 32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scan.md
# regfile_scan

Sequential read-side scanner for the 32×32 CPU register file. On a start pulse it walks a contiguous, optionally wrapping range of register addresses through one register-file read port. Each value it captures goes out as a word on a valid/ready stream toward the debug/display path (UART dumper, LED/7-seg driver). It is the reader counterpart to the register file's write port and never writes the register file.

## Interface
Parameters:
- DATA_WIDTH, 32, register word width
- ADDR_WIDTH, 5, register address width; scan modulus is 2^ADDR_WIDTH

Ports:
- clock  in  1  single clock, rising edge
- ctrl_reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  cancel the current scan
- first_reg  in  ADDR_WIDTH  first address, sampled with start
- last_reg  in  ADDR_WIDTH  last address, sampled with start
- ctrl_readReg  out  ADDR_WIDTH  address to the register-file read port
- data_readReg  in  DATA_WIDTH  combinational read data for ctrl_readReg
- out_valid  out  1  stream word valid
- out_ready  in  1  sink accepts the word
- out_data  out  DATA_WIDTH  captured register value
- out_addr  out  ADDR_WIDTH  address the value was read from
- out_last  out  1  word is the final word of the scan
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- FSM states:
  - IDLE: start latches first_reg→cur and last_reg→end. Next state is READ.
  - READ: drive ctrl_readReg=cur and capture data_readReg into out_data, with out_addr=cur and out_last=(cur==end). Next state is SEND.
  - SEND: out_valid=1. On out_valid&&out_ready, if out_last the next state is DONE; otherwise cur←cur+1 (mod 2^ADDR_WIDTH) and the next state is READ.
  - DONE: done=1 for one cycle. Next state is IDLE.
- Wrap-around: first_reg>last_reg scans first..31, then 0..last. The word count is ((last−first) mod 32)+1. first==last gives exactly one word.
- Register 0 is read like any other address; it returns 0 from the register file.
- start while not in IDLE is ignored.
- abort in READ or SEND forces the next state to IDLE with no done pulse.
  - abort coinciding with a SEND handshake: the word counts as delivered, the next state is still IDLE, and no done pulse is issued.
  - abort in IDLE or DONE has no effect.
- out_data, out_addr and out_last hold stable while out_valid && !out_ready. out_valid never drops without a handshake, except on abort or reset.
- In IDLE and DONE, ctrl_readReg holds its last value. It is combinationally harmless.

## Timing
- Reset values (asynchronous, immediate): state IDLE, out_valid 0, out_data 0, out_addr 0, out_last 0, busy 0, done 0, ctrl_readReg 0, cur 0, end 0.
- Reset asserted mid-scan drops out_valid in the same cycle. The scan is lost with no done pulse.
- start accepted at edge E0 (READ during cycle E0–E1). First out_valid is visible in the cycle after edge E1.
- Throughput is 1 word per 2 cycles with out_ready held high. An N-word scan takes 2N+1 cycles from start to the done pulse, plus back-pressure stalls.
- Latency from handshake to the next out_valid is 2 cycles (READ, then SEND).
- busy is registered. It rises the cycle after start and falls the cycle after DONE.
- All outputs are registered except ctrl_readReg. ctrl_readReg is driven from the cur register and is valid throughout READ.

## Structure
- Shared package: state enum (IDLE, READ, SEND, DONE), REG_COUNT=32, default DATA_WIDTH/ADDR_WIDTH constants.
- Single module, no sub-module.
- Address increment is a plain ADDR_WIDTH-bit add that wraps naturally.

## Test plan
- Scan 1..31, out_ready tied 1, register file preloaded with reg[i]=i×0x11 → 31 words, out_addr 1..31, out_data = i×0x11, out_last only on reg 31, done 63 cycles after start.
- first=30, last=2, random out_ready stalls → addresses 30,31,0,1,2 in order; the reg 0 word is 0; out_data stable during each stall.
- first=last=8, reg 8=0xDEADBEEF → exactly one word with out_last=1, then done; busy high for 3 cycles.
- abort during the third SEND with out_ready=1 in the same cycle → that word is delivered, IDLE next cycle, no done pulse, no further words.
- ctrl_reset_n pulsed low mid-scan → out_valid and busy go 0 immediately. A new start after release runs a complete scan correctly.
- start pulsed repeatedly while busy → ignored. The scan completes with the original range.
